// File: rtl/tdc_record_uart_packer.sv
// tdc_record_uart_packer
// Buffers 48-bit TDC records {calib2, calib1, time1} from the measurement
// sequencer in a small FIFO and serializes each one to a byte-wide UART
// transmitter as an 8-byte frame: sync, six data bytes, XOR checksum.
// Backpressure is applied upstream by withholding the done pulse while full.

module tdc_record_uart_packer #(
  parameter int           DEPTH     = 8,
  parameter int           ADDR_W    = 3,
  parameter logic [7:0]   SYNC_BYTE = 8'hA5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [47:0]       data_in,
  output logic              fifo_writing_done,
  output logic [7:0]        tx_data,
  output logic              new_tx_data,
  input  logic              tx_busy,
  input  logic              flush,
  output logic [ADDR_W:0]   fifo_count,
  output logic              frame_active
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SEND,
    GAP
  } state_t;

  localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

  logic [47:0]       mem [DEPTH];
  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W-1:0] rptr;
  logic              armed;
  logic [47:0]       rd_data;
  logic [47:0]       shreg;
  logic [7:0]        csum;
  logic [2:0]        idx;
  state_t            state;
  logic              push;
  logic              pop;

  // A request is taken once per wr_en assertion, only while a slot is free
  // and the buffer is not being flushed.
  assign push = wr_en & armed & ~flush & (fifo_count != FULL_COUNT);

  // The read side only pulls a record when it is ready to start a new frame.
  assign pop  = (state == IDLE) & ~flush & (fifo_count != '0);

  // Record storage and registered read port.
  // NOTE: the storage array has no reset; its contents are only ever read
  // after being written, and leaving it out of reset lets it map to RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= data_in;
    end
    if (pop) begin
      rd_data <= mem[rptr];
    end
  end

  // Pointer and occupancy bookkeeping; flush empties the buffer at once.
  // NOTE: every sequential block uses non-blocking assignments so all
  // registers update from the same pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr       <= '0;
      rptr       <= '0;
      fifo_count <= '0;
    end else if (flush) begin
      wptr       <= '0;
      rptr       <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wptr <= wptr + ADDR_W'(1);
      end
      if (pop) begin
        rptr <= rptr + ADDR_W'(1);
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + (ADDR_W + 1)'(1);
        2'b01:   fifo_count <= fifo_count - (ADDR_W + 1)'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Write handshake: done pulses the cycle after capture, and the request
  // is re-armed only after upstream drops wr_en.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fifo_writing_done <= 1'b0;
      armed             <= 1'b1;
    end else begin
      fifo_writing_done <= push;
      if (push) begin
        armed <= 1'b0;
      end else if (!wr_en) begin
        armed <= 1'b1;
      end
    end
  end

  // Frame serializer: pop, load, then alternate SEND/GAP for eight bytes.
  // GAP skips one cycle of tx_busy so the UART's busy flag has time to rise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      shreg        <= '0;
      csum         <= '0;
      idx          <= '0;
      tx_data      <= 8'h00;
      new_tx_data  <= 1'b0;
      frame_active <= 1'b0;
    end else begin
      new_tx_data <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            state        <= LOAD;
            frame_active <= 1'b1;
          end
        end
        LOAD: begin
          shreg <= rd_data;
          csum  <= rd_data[47:40] ^ rd_data[39:32] ^ rd_data[31:24]
                 ^ rd_data[23:16] ^ rd_data[15:8]  ^ rd_data[7:0];
          idx   <= '0;
          state <= SEND;
        end
        SEND: begin
          if (!tx_busy) begin
            new_tx_data <= 1'b1;
            state       <= GAP;
            case (idx)
              3'd0:    tx_data <= SYNC_BYTE;
              3'd7:    tx_data <= csum;
              default: begin
                tx_data <= shreg[47:40];
                shreg   <= {shreg[39:0], 8'h00};
              end
            endcase
          end
        end
        GAP: begin
          if (idx == 3'd7) begin
            state        <= IDLE;
            frame_active <= 1'b0;
          end else begin
            idx   <= idx + 3'd1;
            state <= SEND;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tdc_record_uart_packer.sv
// tb_tdc_record_uart_packer
// Directed bench for the TDC record UART packer: inputs are driven on the
// falling edge, outputs are observed on the falling edge, and every strobed
// byte is collected into a queue and compared against expected frames.

module tb_tdc_record_uart_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [47:0] data_in;
  logic        fifo_writing_done;
  logic [7:0]  tx_data;
  logic        new_tx_data;
  logic        tx_busy;
  logic        flush;
  logic [3:0]  fifo_count;
  logic        frame_active;

  logic        busy_force = 1'b0;
  logic        busy_auto  = 1'b0;
  logic        auto_mode  = 1'b0;
  logic        busy_q     = 1'b0;
  int          busy_timer = 0;

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  int          done_cnt = 0;
  int          done_cyc = 0;
  int          peak = 0;
  int          viol = 0;
  logic [7:0]  rx_q[$];
  int          rx_cyc[$];

  assign tx_busy = busy_force | busy_auto;

  tdc_record_uart_packer #(
    .DEPTH    (8),
    .ADDR_W   (3),
    .SYNC_BYTE(8'hA5)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .wr_en            (wr_en),
    .data_in          (data_in),
    .fifo_writing_done(fifo_writing_done),
    .tx_data          (tx_data),
    .new_tx_data      (new_tx_data),
    .tx_busy          (tx_busy),
    .flush            (flush),
    .fifo_count       (fifo_count),
    .frame_active     (frame_active)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    busy_q <= tx_busy;
  end

  // Collect strobes, done pulses and peak occupancy.
  always @(negedge clk) begin
    if (new_tx_data) begin
      rx_q.push_back(tx_data);
      rx_cyc.push_back(cyc);
      if (busy_q) viol++;
    end
    if (fifo_writing_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (int'(fifo_count) > peak) peak = int'(fifo_count);
  end

  // UART model: busy for 10 cycles after each strobe when enabled.
  always @(negedge clk) begin
    if (auto_mode) begin
      if (new_tx_data) busy_timer = 10;
      else if (busy_timer > 0) busy_timer--;
      busy_auto = (busy_timer > 0);
    end else begin
      busy_timer = 0;
      busy_auto  = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    @(posedge clk);
    rx_q.delete();
    rx_cyc.delete();
    done_cnt = 0;
    peak     = 0;
    viol     = 0;
  endtask

  // Upstream sequencer write: hold wr_en until done, then keep it `hold` more cycles.
  task automatic write_rec(input logic [47:0] d, input int hold);
    int n;
    n = 0;
    @(negedge clk);
    wr_en   = 1'b1;
    data_in = d;
    do begin
      @(negedge clk);
      n++;
    end while (!fifo_writing_done && n < 400);
    check("write_done", fifo_writing_done, 1'b1);
    repeat (hold) @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_bytes(input int n, input int budget);
    int k;
    k = 0;
    while (rx_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("bytes_rcvd", rx_q.size(), n);
  endtask

  function automatic logic [7:0] fbyte(input logic [47:0] r, input int j);
    logic [7:0] b;
    case (j)
      0:       b = 8'hA5;
      7:       b = r[47:40] ^ r[39:32] ^ r[31:24] ^ r[23:16] ^ r[15:8] ^ r[7:0];
      default: b = r[55 - 8*j -: 8];
    endcase
    return b;
  endfunction

  // Compare collected bytes with expected frames; exact_gap=0 means only the 2-cycle minimum.
  task automatic check_frames(input logic [47:0] recs[$], input int exact_gap);
    for (int i = 0; i < recs.size(); i++) begin
      for (int j = 0; j < 8; j++) begin
        int p;
        p = i * 8 + j;
        if (p < rx_q.size()) begin
          check($sformatf("rec%0d_byte%0d", i, j), rx_q[p], fbyte(recs[i], j));
          if (j > 0) begin
            if (exact_gap > 0)
              check($sformatf("rec%0d_gap%0d", i, j), rx_cyc[p] - rx_cyc[p-1], exact_gap);
            else
              check($sformatf("rec%0d_mingap%0d", i, j), (rx_cyc[p] - rx_cyc[p-1]) >= 2, 1'b1);
          end
        end
      end
    end
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [47:0] recs[$];
    int          n;
    int          sz;

    rst     = 1'b0;
    wr_en   = 1'b0;
    data_in = '0;
    flush   = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_done",  fifo_writing_done, 1'b0);
    check("rst_strobe", new_tx_data, 1'b0);
    check("rst_txdata", tx_data, 8'h00);
    check("rst_count", fifo_count, 4'd0);
    check("rst_active", frame_active, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Single record: checksum 12^34^56^78^9A^BC = 2E
    clear_mon();
    write_rec(48'h1234_5678_9ABC, 0);
    wait_bytes(8, 100);
    check("single_dones", done_cnt, 1);
    if (rx_cyc.size() > 0) check("single_latency", rx_cyc[0] - done_cyc, 3);
    if (rx_q.size() == 8) check("single_csum", rx_q[7], 8'h2E);
    recs = '{48'h1234_5678_9ABC};
    check_frames(recs, 2);
    repeat (3) @(negedge clk);
    check("single_count", fifo_count, 4'd0);
    check("single_active", frame_active, 1'b0);

    // Held wr_en: one capture only
    clear_mon();
    write_rec(48'hCAFE_0123_4567, 5);
    wait_bytes(8, 100);
    repeat (20) @(negedge clk);
    check("held_dones", done_cnt, 1);
    check("held_peak", peak, 1);
    check("held_bytes", rx_q.size(), 8);
    recs = '{48'hCAFE_0123_4567};
    check_frames(recs, 2);

    // Full backpressure. The first record is popped into the stalled frame,
    // so nine captures fill the eight slots and the tenth is withheld.
    clear_mon();
    busy_force = 1'b1;
    recs.delete();
    for (int i = 0; i < 10; i++) recs.push_back({16'hB000 + 16'(i), 16'h1111 * 16'(i), 16'h0F0F ^ 16'(i)});
    for (int i = 0; i < 9; i++) write_rec(recs[i], 0);
    repeat (2) @(negedge clk);
    check("bp_dones9", done_cnt, 9);
    check("bp_full", fifo_count, 4'd8);
    @(negedge clk);
    wr_en   = 1'b1;
    data_in = recs[9];
    repeat (20) @(negedge clk);
    check("bp_withheld", done_cnt, 9);
    check("bp_still_full", fifo_count, 4'd8);
    check("bp_no_bytes", rx_q.size(), 0);
    busy_force = 1'b0;
    n = 0;
    while (!fifo_writing_done && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("bp_late_done", fifo_writing_done, 1'b1);
    wr_en = 1'b0;
    check("bp_late_after_frame", rx_q.size(), 8);
    wait_bytes(80, 2000);
    check_frames(recs, 2);
    repeat (3) @(negedge clk);
    check("bp_count_end", fifo_count, 4'd0);
    check("bp_dones10", done_cnt, 10);

    // UART throttling
    clear_mon();
    auto_mode = 1'b1;
    recs = '{48'h0102_0304_0506, 48'hFFEE_DDCC_BBAA};
    write_rec(recs[0], 0);
    write_rec(recs[1], 0);
    wait_bytes(16, 1000);
    check("thr_busy_viol", viol, 0);
    check_frames(recs, 0);
    auto_mode = 1'b0;
    repeat (3) @(negedge clk);

    // Wrap-around with alternating patterns
    clear_mon();
    recs.delete();
    for (int i = 0; i < 20; i++)
      recs.push_back((i % 2 == 0) ? (48'hAAAA_5555_0000 | 48'(i)) : (48'h5555_AAAA_FF00 | 48'(i)));
    for (int i = 0; i < 20; i++) write_rec(recs[i], 0);
    wait_bytes(160, 4000);
    check_frames(recs, 2);
    repeat (3) @(negedge clk);
    check("wrap_count_end", fifo_count, 4'd0);
    check("wrap_dones", done_cnt, 20);

    // Flush mid-frame with three records stored
    clear_mon();
    busy_force = 1'b1;
    recs = '{48'h1111_2222_3333, 48'h4444_5555_6666, 48'h7777_8888_9999, 48'hABCD_EF01_2345};
    for (int i = 0; i < 4; i++) write_rec(recs[i], 0);
    repeat (2) @(negedge clk);
    check("flush_stored", fifo_count, 4'd3);
    busy_force = 1'b0;
    wait_bytes(3, 100);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_count", fifo_count, 4'd0);
    wait_bytes(8, 100);
    repeat (60) @(negedge clk);
    check("flush_bytes", rx_q.size(), 8);
    check("flush_active", frame_active, 1'b0);
    check("flush_count_end", fifo_count, 4'd0);
    recs = '{48'h1111_2222_3333};
    check_frames(recs, 2);

    // Reset mid-frame
    clear_mon();
    write_rec(48'h0BAD_F00D_BEEF, 0);
    wait_bytes(3, 100);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mrst_strobe", new_tx_data, 1'b0);
    check("mrst_txdata", tx_data, 8'h00);
    check("mrst_active", frame_active, 1'b0);
    check("mrst_count", fifo_count, 4'd0);
    check("mrst_done", fifo_writing_done, 1'b0);
    sz = rx_q.size();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (50) @(negedge clk);
    check("mrst_no_more", rx_q.size(), sz);
    check("mrst_partial", sz < 8, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
